// File: rtl/sim_test_ctrl.sv
// Passive simulation test controller: snoops data-write handshakes, decodes a
// small MMIO window (status / char FIFO / watchdog kick) and reports sticky results.
module sim_test_ctrl #(
    parameter int unsigned          BUS_WIDTH      = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR      = 'h8000,
    parameter logic [BUS_WIDTH-1:0] PASS_CODE      = 'd123456789,
    parameter logic [BUS_WIDTH-1:0] FAIL_CODE      = 'd111111111,
    parameter int unsigned          TIMEOUT_CYCLES = 100000,
    parameter bit                   KICK_ON_ANY    = 1'b0,
    parameter int unsigned          FIFO_DEPTH     = 16,
    parameter int unsigned          CNT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dw_data_addr_valid,
    input  logic                   dw_data_addr_ready,
    input  logic [BUS_WIDTH-1:0]   dw_addr,
    input  logic [BUS_WIDTH-1:0]   dw_data,
    input  logic [BUS_WIDTH/8-1:0] dw_strobe,
    output logic [7:0]             char_data,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic                   done,
    output logic                   passed,
    output logic                   failed,
    output logic                   timed_out,
    output logic                   char_overflow,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [BUS_WIDTH-1:0] ADDR_STATUS = BASE_ADDR;
    localparam logic [BUS_WIDTH-1:0] ADDR_CHAR   = BASE_ADDR + BUS_WIDTH'(4);
    localparam logic [BUS_WIDTH-1:0] ADDR_KICK   = BASE_ADDR + BUS_WIDTH'(8);
    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic        accept, hit_status, pass_ev, fail_ev, kick, expire;
    logic        push_req, do_push, pop, full;
    logic [31:0] wd_cnt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign accept     = dw_data_addr_valid && dw_data_addr_ready;
    assign hit_status = accept && (dw_addr == ADDR_STATUS) && (&dw_strobe);
    assign pass_ev    = hit_status && (dw_data == PASS_CODE);
    assign fail_ev    = hit_status && (dw_data == FAIL_CODE);
    assign kick       = accept && (KICK_ON_ANY || (dw_addr == ADDR_KICK));
    // A kick landing on the last count keeps the test alive.
    assign expire     = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST) && !kick;

    // Result flags, watchdog and cycle counter; the first terminating event freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            passed      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
            wd_cnt      <= '0;
            cycle_count <= '0;
        end else begin
            if (!done) begin
                if (pass_ev)      passed    <= 1'b1;
                else if (fail_ev) failed    <= 1'b1;
                else if (expire)  timed_out <= 1'b1;
                if (pass_ev || fail_ev || expire) done <= 1'b1;
                cycle_count <= cycle_count + 1'b1;
            end
            if (kick)
                wd_cnt <= '0;
            else if (!done && (TIMEOUT_CYCLES != 0))
                wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign push_req   = accept && (dw_addr == ADDR_CHAR) && dw_strobe[0];
    assign char_valid = (count != '0);
    assign full       = (count == FULL_CNT);
    assign pop        = char_valid && char_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_push    = push_req && (!full || pop);
    assign char_data  = char_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= dw_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            char_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            if (push_req && full && !pop) char_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sim_test_ctrl.sv
// Directed bench for sim_test_ctrl: 20-cycle watchdog, 4-entry char FIFO.
module tb_sim_test_ctrl;

    localparam int unsigned TO = 20;
    localparam logic [31:0] PASS = 32'd123456789;
    localparam logic [31:0] FAILC = 32'd111111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dw_data_addr_valid = 1'b0;
    logic        dw_data_addr_ready = 1'b0;
    logic [31:0] dw_addr = '0;
    logic [31:0] dw_data = '0;
    logic [3:0]  dw_strobe = '0;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic        done, passed, failed, timed_out, char_overflow;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    sim_test_ctrl #(
        .BUS_WIDTH(32), .BASE_ADDR(32'h8000), .PASS_CODE(PASS), .FAIL_CODE(FAILC),
        .TIMEOUT_CYCLES(TO), .KICK_ON_ANY(1'b0), .FIFO_DEPTH(4), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
        .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .done(done), .passed(passed), .failed(failed), .timed_out(timed_out),
        .char_overflow(char_overflow), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dw_addr = a; dw_data = d; dw_strobe = s;
        dw_data_addr_valid = 1'b1; dw_data_addr_ready = 1'b1;
        cyc(1);
        dw_data_addr_valid = 1'b0; dw_data_addr_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; char_ready = 1'b0;
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cnt0: got %0d expected 0", cycle_count); end
        cyc(5);
        checks++; if ({done, passed, failed, timed_out, char_overflow, char_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {done, passed, failed, timed_out, char_overflow, char_valid}); end
        checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL reset_char: got %0h expected 0", char_data); end
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL reset_cnt5: got %0d expected 5", cycle_count); end
    endtask

    task automatic test_pass();
        do_reset();
        cyc(3);
        wr(32'h8000, PASS, 4'hF);
        checks++; if ({done, passed, failed, timed_out} !== 4'b1100) begin
            errors++; $display("FAIL pass_flags: got %b expected 1100", {done, passed, failed, timed_out}); end
        checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL pass_cnt: got %0d expected 4", cycle_count); end
        wr(32'h8000, FAILC, 4'hF);
        checks++; if (failed !== 1'b0) begin errors++; $display("FAIL pass_then_fail: got %b expected 0", failed); end
        cyc(30);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL pass_no_expiry: got %b expected 0", timed_out); end
        checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL pass_cnt_frozen: got %0d expected 4", cycle_count); end
    endtask

    task automatic test_fail();
        do_reset();
        cyc(2);
        wr(32'h8000, FAILC, 4'hF);
        checks++; if ({done, passed, failed, timed_out} !== 4'b1010) begin
            errors++; $display("FAIL fail_flags: got %b expected 1010", {done, passed, failed, timed_out}); end
    endtask

    task automatic test_timeout();
        do_reset();
        cyc(19);
        checks++; if ({done, timed_out} !== 2'b00) begin errors++; $display("FAIL to_early: got %b expected 00", {done, timed_out}); end
        cyc(1);
        checks++; if ({done, timed_out, passed} !== 3'b110) begin errors++; $display("FAIL to_expire: got %b expected 110", {done, timed_out, passed}); end
        checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL to_cnt: got %0d expected 20", cycle_count); end
        cyc(5);
        checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL to_cnt_frozen: got %0d expected 20", cycle_count); end
    endtask

    task automatic test_kick();
        do_reset();
        cyc(14);
        wr(32'h8008, 32'hDEAD, 4'h0);
        cyc(19);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL kick_early: got %b expected 0 at cycle 34", timed_out); end
        cyc(1);
        checks++; if ({done, timed_out} !== 2'b11) begin errors++; $display("FAIL kick_expire: got %b expected 11 at cycle 35", {done, timed_out}); end
    endtask

    task automatic test_char();
        do_reset();
        wr(32'h8004, 32'h48, 4'h1);
        checks++; if ({char_valid, char_data} !== {1'b1, 8'h48}) begin errors++; $display("FAIL char_H: got %b/%0h expected 1/48", char_valid, char_data); end
        wr(32'h8004, 32'h69, 4'h1);
        char_ready = 1'b1;
        checks++; if (char_data !== 8'h48) begin errors++; $display("FAIL char_head: got %0h expected 48", char_data); end
        cyc(1);
        checks++; if ({char_valid, char_data} !== {1'b1, 8'h69}) begin errors++; $display("FAIL char_i: got %b/%0h expected 1/69", char_valid, char_data); end
        cyc(1);
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL char_empty: got %b expected 0", char_valid); end
        char_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 5; i++) wr(32'h8004, 32'h61 + i, 4'h1);
        checks++; if (char_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", char_overflow); end
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c = 8'h61 + 8'(i);
            checks++; if ({char_valid, char_data} !== {1'b1, c}) begin errors++; $display("FAIL ovf_drain%0d: got %b/%0h expected 1/%0h", i, char_valid, char_data, c); end
            cyc(1);
        end
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", char_valid); end
        char_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h62; exp_q[1] = 8'h63; exp_q[2] = 8'h64; exp_q[3] = 8'h78;
        do_reset();
        for (int i = 0; i < 4; i++) wr(32'h8004, 32'h61 + i, 4'h1);
        char_ready = 1'b1;
        wr(32'h8004, 32'h78, 4'h1);
        char_ready = 1'b0;
        checks++; if (char_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf: got %b expected 0", char_overflow); end
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({char_valid, char_data} !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL b2b_drain%0d: got %b/%0h expected 1/%0h", i, char_valid, char_data, exp_q[i]); end
            cyc(1);
        end
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", char_valid); end
        char_ready = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        cyc(19);
        wr(32'h8000, PASS, 4'hF);
        checks++; if ({done, passed, timed_out} !== 3'b110) begin errors++; $display("FAIL prio_pass: got %b expected 110", {done, passed, timed_out}); end
    endtask

    task automatic test_partial();
        do_reset();
        cyc(2);
        wr(32'h8000, PASS, 4'h1);
        wr(32'h800C, PASS, 4'hF);
        checks++; if ({done, passed, failed} !== 3'b000) begin errors++; $display("FAIL partial_ignored: got %b expected 000", {done, passed, failed}); end
        dw_addr = 32'h8000; dw_data = PASS; dw_strobe = 4'hF;
        dw_data_addr_valid = 1'b1; dw_data_addr_ready = 1'b0;
        cyc(1);
        dw_data_addr_valid = 1'b0;
        checks++; if (passed !== 1'b0) begin errors++; $display("FAIL no_handshake: got %b expected 0", passed); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) wr(32'h8004, 32'h30 + i, 4'h1);
        wr(32'h8000, PASS, 4'hF);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        checks++; if ({done, passed, char_overflow, char_valid} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: got %b expected 0000", {done, passed, char_overflow, char_valid}); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_kick();
        test_char();
        test_overflow();
        test_back_to_back();
        test_priority();
        test_partial();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_test_ctrl.md
Name: sim_test_ctrl

Overview:
- Parametrised, passive test-control device snooping the core's data-write channel (dw_*).
- Decodes a small MMIO window:
  - pass/fail status word;
  - character output port, buffered in a FIFO;
  - watchdog kick.
- Keeps a watchdog timer and a cycle counter, and reports sticky done/passed/failed/timed_out flags to the bench top.
- Never drives ready; observes handshakes only.

Parameters:
- BUS_WIDTH, 32, width of dw_addr/dw_data
- BASE_ADDR, 32'h8000, base of the MMIO window
- PASS_CODE, 32'd123456789, status value meaning pass
- FAIL_CODE, 32'd111111111, status value meaning fail
- TIMEOUT_CYCLES, 100000, watchdog limit in cycles; 0 disables the watchdog
- KICK_ON_ANY, 0, 1 = any accepted write kicks the watchdog; 0 = only a KICK write kicks it
- FIFO_DEPTH, 16, character FIFO entries (power of two, >=2)
- CNT_WIDTH, 32, cycle_count width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dw_data_addr_valid  in  1  write valid
- dw_data_addr_ready  in  1  write ready
- dw_addr  in  BUS_WIDTH  write address
- dw_data  in  BUS_WIDTH  write data
- dw_strobe  in  BUS_WIDTH/8  byte strobes
- char_data  out  8  FIFO head character
- char_valid  out  1  FIFO non-empty
- char_ready  in  1  consumer accepts char_data
- done  out  1  sticky: test ended by any cause
- passed  out  1  sticky pass
- failed  out  1  sticky fail
- timed_out  out  1  sticky watchdog expiry
- char_overflow  out  1  sticky: a character was dropped
- cycle_count  out  CNT_WIDTH  cycles since reset; frozen once done=1

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, FIFO empty, watchdog counter 0, cycle_count 0. Reset mid-operation discards FIFO contents and clears every sticky flag.
- Accept event: dw_data_addr_valid && dw_data_addr_ready on a rising clk edge. Only accept events are decoded.
- Register map (offsets from BASE_ADDR; any other address is ignored):
  - +0x0 STATUS, requires all strobes set:
    - data==PASS_CODE -> passed=1;
    - data==FAIL_CODE -> failed=1;
    - any other value is ignored.
  - +0x4 CHAR, requires dw_strobe[0]; pushes dw_data[7:0].
  - +0x8 KICK: clears the watchdog counter; data is ignored.
- Flag timing: flags are registered and visible the cycle after the accept. done = passed|failed|timed_out, also registered.
- First terminating event wins. Once done=1, passed/failed/timed_out are frozen, and later STATUS writes and expiry are ignored.
- CHAR writes and FIFO draining continue after done.
- Watchdog:
  - Counter increments every cycle while !done and TIMEOUT_CYCLES!=0.
  - Cleared on a KICK write, or on any accept when KICK_ON_ANY=1.
  - Expiry: when the counter reaches TIMEOUT_CYCLES-1 and no kick occurs that cycle, timed_out=1 next cycle.
  - Priority: same-cycle STATUS pass/fail beats expiry (passed/failed set, timed_out stays 0). A kick in the expiry cycle prevents expiry.
- cycle_count: increments every cycle after reset while !done. Wraps modulo 2^CNT_WIDTH. Holds its value once done=1.
- FIFO:
  - Synchronous, first-word fall-through: char_data is valid whenever char_valid=1.
  - Pop on char_valid && char_ready.
  - Push when full with no same-cycle pop: character dropped, char_overflow=1 (sticky), contents unchanged.
  - Push when full with a same-cycle pop: both succeed, count unchanged.
  - Push when empty: char_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count uses log2(FIFO_DEPTH)+1 bits.
- Status word is compared on the full BUS_WIDTH; byte-partial STATUS writes are ignored.

Test Plan:
- Reset held 3 cycles, then release, idle 5 cycles -> all flags 0, char_valid=0, cycle_count=5.
- Write 0x8000=123456789, strobe 4'hF -> passed=1, done=1 one cycle later. A following write 0x8000=111111111 -> failed stays 0; cycle_count frozen.
- TIMEOUT_CYCLES=20, no writes -> timed_out=1, done=1 at cycle 20 after reset. Repeat with a KICK write at cycle 15 -> no expiry until cycle 35.
- Writes of 'H','i' to 0x8004 with char_ready=0 -> char_valid=1, char_data='H'. Raise char_ready -> 'H' then 'i', then char_valid=0.
- FIFO_DEPTH=4, char_ready=0, 5 CHAR writes -> char_overflow=1, drained order is chars 1-4. Full FIFO with simultaneous push+pop -> no overflow, count stays 4.
- Same cycle: STATUS=PASS_CODE accepted while the watchdog reaches its limit -> passed=1, timed_out=0. Write 0x8000=PASS_CODE with strobe 4'h1 -> no effect.
